vgachargen_pixel_pipe: RTL and testbench
========================================

Name: vgachargen_pixel_pipe

Overview:
Consumer of port B of the character-map dual-port BRAM (APB writes via port A). Generates 640x480 VGA timing, fetches the character word for each pixel cell from the char map, then looks up the glyph row in a separate font BRAM (same one-cycle-read BRAM type). Produces registered RGB444 plus hsync/vsync, all aligned at the output. Sits between the char-map/font memories and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses driven low
CHARMAP_ADDR_WIDTH, 12, char-map address width (80x30 = 2400 cells)
FONT_ADDR_WIDTH, 12, font address width ({code[7:0], row[3:0]})

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
pix_en_i  in  1  pixel strobe; pipeline and counters advance only when high
charmap_addr_o  out  CHARMAP_ADDR_WIDTH  char-map port-B address (addrb)
charmap_data_i  in  16  char-map port-B data: [7:0] code, [11:8] fg index, [15:12] bg index
font_addr_o  out  FONT_ADDR_WIDTH  font BRAM read address
font_data_i  in  8  glyph row; bit 7 = leftmost pixel
vga_r_o  out  4  red
vga_g_o  out  4  green
vga_b_o  out  4  blue
vga_hs_o  out  1  horizontal sync
vga_vs_o  out  1  vertical sync

Behaviour:
- All state changes gated by pix_en_i; with pix_en_i low, every register holds. pix_en_i may be high every cycle or in any sparser pattern; output sequence per strobe is identical in all cases.
- S0: hcnt 0..H_TOTAL-1 (800), vcnt 0..V_TOTAL-1 (525). hcnt wraps to 0 at H_TOTAL-1; vcnt increments on that wrap and itself wraps at V_TOTAL-1.
- charmap_addr_o combinational from S0: (vcnt>>4)*80 + (hcnt>>3). Constant multiply by 80 done as shift-add; no DSP. Value during blanking is don't-care but must stay in range (clamp col/row to 0 when outside active area).
- S1 (on pix_en_i): capture charmap_data_i; delay hcnt[2:0], vcnt[3:0], active, hsync, vsync.
- font_addr_o combinational from S1: {code, vrow[3:0]}.
- S2: capture font_data_i, fg, bg; delay col[2:0], active, syncs.
- S3 (output regs): pixel bit = font[7-col]; index = bit ? fg : bg; RGB = PALETTE[index]; forced 0 when not active. Syncs registered here.
- Latency: 3 pix_en strobes from counter value to its RGB/sync at the outputs. Syncs are delayed by the same 3 strobes, so they stay aligned with RGB.
- hsync asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751]. vsync asserted for vcnt in [490, 491]. Asserted level = 0 when SYNC_ACTIVE_LOW.
- BRAM one-clock read latency is always covered: an address changes only on a strobe and is consumed no earlier than the next strobe.
- Reset (any time, including mid-frame): counters to (0,0); all pipeline valid/active bits cleared; RGB = 0; syncs deasserted (1 when active-low). The first 3 strobes after reset output blank. Char-map writes landing mid-frame take effect on the next fetch; no tearing protection.

Decomposition:
- Package vgachargen_pkg: timing defaults, H_TOTAL/V_TOTAL, CHAR_W = 8, CHAR_H = 16, COLS = 80, ROWS = 30, packed struct charmap_word_t {bg, fg, code}, 16-entry RGB444 PALETTE constant.
- Sub-module vga_timing_gen: counters plus active/hsync/vsync flags. Remainder (fetch pipeline and palette) stays in the top.

Test Plan:
- Reset with rst_i=1 for 2 cycles -> RGB=0x000, hs=vs=1; after release, the first 3 strobes stay blank.
- charmap[0]=0x0F41, font[0x410]=0x18, PALETTE[F]=0xFFF, PALETTE[0]=0x000, pix_en_i always 1 -> line 0 pixels 0..7 = 000,000,000,FFF,FFF,000,000,000, starting 3 cycles after reset release.
- Free run one frame -> hs low for exactly 96 strobes starting at output strobe 656+3 of each line; vs low for lines 490-491; 800x525 strobes per frame.
- pix_en_i high 1 in 4 cycles, same memory contents as the previous scenario -> per-strobe output sequence identical; outputs hold between strobes.
- Write charmap[81]=0x2A42 -> line 16 pixels 8..15 use fg 0xA, bg 0x2, glyph font[0x420]; address 81 presented on charmap_addr_o at hcnt=8, vcnt=16.
- Assert rst_i at hcnt=300, vcnt=200 -> next strobe outputs blank; counters restart at (0,0) and the frame timing matches the post-reset run.

Source files
------------

// File: rtl/vgachargen_pkg.sv
// Shared timing defaults, character-cell geometry, char-map word layout and
// the 16-colour RGB444 palette for the character-generator pixel pipe.
package vgachargen_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;

  localparam int CHARMAP_ADDR_WIDTH = 12;
  localparam int FONT_ADDR_WIDTH    = 12;
  localparam int HCNT_W             = 10;
  localparam int VCNT_W             = 10;

  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
    logic [7:0] code;
  } charmap_word_t;

  // Entry 0 is the rightmost element; {r,g,b} nibbles.
  localparam logic [15:0][11:0] PALETTE = {
    12'hFFF, 12'hFF5, 12'hF5F, 12'hF55, 12'h5FF, 12'h5F5, 12'h55F, 12'h555,
    12'hAAA, 12'hA50, 12'hA0A, 12'hA00, 12'h0AA, 12'h0A0, 12'h00A, 12'h000
  };

endpackage

// File: rtl/vgachargen_pixel_pipe_if.sv
// Read ports toward the char-map (port B) and font BRAMs.
interface vgachargen_mem_if;
  import vgachargen_pkg::*;

  logic [CHARMAP_ADDR_WIDTH-1:0] charmap_addr;
  logic [15:0]                   charmap_data;
  logic [FONT_ADDR_WIDTH-1:0]    font_addr;
  logic [7:0]                    font_data;

  // Addresses change only on a pixel strobe; data for an address is
  // expected to be valid by the next strobe.
  modport master (output charmap_addr, output font_addr,
                  input  charmap_data, input  font_data);
  modport slave  (input  charmap_addr, input  font_addr,
                  output charmap_data, output font_data);
endinterface

// File: rtl/vgachargen_pixel_pipe_timing.sv
// VGA raster counters with active-area and sync flags (sync flags are
// active-high here; polarity is applied at the output pins).
module vga_timing_gen
  import vgachargen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pix_en_i,
  output logic [HCNT_W-1:0] hcnt_o,
  output logic [VCNT_W-1:0] vcnt_o,
  output logic              active_o,
  output logic              hsync_o,
  output logic              vsync_o
);

  localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en_i) begin
      if (hcnt_q == HCNT_W'(LINE_LEN - 1)) begin
        hcnt_d = '0;
        if (vcnt_q == VCNT_W'(FRAME_LINES - 1)) vcnt_d = '0;
        else                                    vcnt_d = vcnt_q + VCNT_W'(1);
      end else begin
        hcnt_d = hcnt_q + HCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o   = hcnt_q;
  assign vcnt_o   = vcnt_q;
  assign active_o = (hcnt_q < HCNT_W'(H_ACTIVE)) && (vcnt_q < VCNT_W'(V_ACTIVE));
  assign hsync_o  = (hcnt_q >= HCNT_W'(H_ACTIVE + H_FP)) &&
                    (hcnt_q <  HCNT_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_o  = (vcnt_q >= VCNT_W'(V_ACTIVE + V_FP)) &&
                    (vcnt_q <  VCNT_W'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vgachargen_pixel_pipe.sv
// Text-mode pixel pipe: raster counters -> char-map fetch -> glyph fetch ->
// palette, with syncs delayed alongside so RGB and sync leave together.
module vgachargen_pixel_pipe
  import vgachargen_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pix_en_i,
  vgachargen_mem_if.master       mem,
  output logic [3:0]             vga_r_o,
  output logic [3:0]             vga_g_o,
  output logic [3:0]             vga_b_o,
  output logic                   vga_hs_o,
  output logic                   vga_vs_o
);

  localparam logic SYNC_INV = (SYNC_ACTIVE_LOW != 0);

  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic              active, hsync, vsync;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pix_en_i (pix_en_i),
    .hcnt_o   (hcnt),
    .vcnt_o   (vcnt),
    .active_o (active),
    .hsync_o  (hsync),
    .vsync_o  (vsync)
  );

  // Cell address row*80 + col as (row<<6)+(row<<4)+col; blanking parks on cell 0.
  logic [5:0] cell_row;
  logic [6:0] cell_col;

  always_comb begin
    cell_row = '0;
    cell_col = '0;
    if (active) begin
      cell_row = vcnt[9:4];
      cell_col = hcnt[9:3];
    end
  end

  assign mem.charmap_addr = {cell_row, 6'b0} + {2'b0, cell_row, 4'b0} + {5'b0, cell_col};

  charmap_word_t word_q, word_d;
  logic [2:0]    hsub1_q, hsub1_d, hsub2_q, hsub2_d;
  logic [3:0]    vrow1_q, vrow1_d;
  logic          act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [7:0]    glyph2_q, glyph2_d;
  logic [3:0]    fg2_q, fg2_d, bg2_q, bg2_d;
  logic          act2_q, act2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          hs3_q, hs3_d, vs3_q, vs3_d;
  logic          pix_bit;
  logic [3:0]    pal_idx;

  assign mem.font_addr = {word_q.code, vrow1_q};

  // Glyph bit 7 is the leftmost pixel of the cell.
  assign pix_bit = glyph2_q[3'd7 - hsub2_q];
  assign pal_idx = pix_bit ? fg2_q : bg2_q;

  always_comb begin
    word_d   = word_q;
    hsub1_d  = hsub1_q;
    vrow1_d  = vrow1_q;
    act1_d   = act1_q;
    hs1_d    = hs1_q;
    vs1_d    = vs1_q;
    glyph2_d = glyph2_q;
    fg2_d    = fg2_q;
    bg2_d    = bg2_q;
    hsub2_d  = hsub2_q;
    act2_d   = act2_q;
    hs2_d    = hs2_q;
    vs2_d    = vs2_q;
    rgb_d    = rgb_q;
    hs3_d    = hs3_q;
    vs3_d    = vs3_q;
    if (pix_en_i) begin
      word_d   = charmap_word_t'(mem.charmap_data);
      hsub1_d  = hcnt[2:0];
      vrow1_d  = vcnt[3:0];
      act1_d   = active;
      hs1_d    = hsync;
      vs1_d    = vsync;
      glyph2_d = mem.font_data;
      fg2_d    = word_q.fg;
      bg2_d    = word_q.bg;
      hsub2_d  = hsub1_q;
      act2_d   = act1_q;
      hs2_d    = hs1_q;
      vs2_d    = vs1_q;
      rgb_d    = act2_q ? PALETTE[pal_idx] : 12'h000;
      hs3_d    = hs2_q;
      vs3_d    = vs2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q   <= '0;
      hsub1_q  <= '0;
      vrow1_q  <= '0;
      act1_q   <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      glyph2_q <= '0;
      fg2_q    <= '0;
      bg2_q    <= '0;
      hsub2_q  <= '0;
      act2_q   <= 1'b0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      rgb_q    <= '0;
      hs3_q    <= 1'b0;
      vs3_q    <= 1'b0;
    end else begin
      word_q   <= word_d;
      hsub1_q  <= hsub1_d;
      vrow1_q  <= vrow1_d;
      act1_q   <= act1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      glyph2_q <= glyph2_d;
      fg2_q    <= fg2_d;
      bg2_q    <= bg2_d;
      hsub2_q  <= hsub2_d;
      act2_q   <= act2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      rgb_q    <= rgb_d;
      hs3_q    <= hs3_d;
      vs3_q    <= vs3_d;
    end
  end

  assign vga_r_o  = rgb_q[11:8];
  assign vga_g_o  = rgb_q[7:4];
  assign vga_b_o  = rgb_q[3:0];
  assign vga_hs_o = hs3_q ^ SYNC_INV;
  assign vga_vs_o = vs3_q ^ SYNC_INV;

endmodule

// File: tb/tb_vgachargen_pixel_pipe.sv
// Bench for vgachargen_pixel_pipe: a raster-level reference model, directed
// pixel tables and mid-frame reset / sparse-strobe sequences.
module tb_vgachargen_pixel_pipe;

  localparam int HT       = 800;
  localparam int HA       = 640;
  localparam int HS_START = 656;
  localparam int HS_END   = 752;
  localparam int VA       = 20;
  localparam int VFP      = 2;
  localparam int VSY      = 2;
  localparam int VBP      = 4;
  localparam int VT       = VA + VFP + VSY + VBP;
  localparam int FRAME    = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_en = 1'b0;
  logic [3:0] r, g, b;
  logic       hs, vs;

  vgachargen_mem_if mem_if();

  logic [15:0] cmap [2400];
  logic [7:0]  font [4096];
  logic [11:0] pal  [16];

  int errors = 0;
  int checks = 0;
  int s      = 0;
  int hs_first, hs_cnt, vs_first, vs_cnt;

  typedef struct {
    int         h;
    int         v;
    logic [11:0] rgb;
  } vec_t;
  vec_t vecs [16];

  always #5 clk = ~clk;

  assign mem_if.charmap_data = (mem_if.charmap_addr < 12'd2400) ? cmap[mem_if.charmap_addr] : 16'hDEAD;
  assign mem_if.font_data    = font[mem_if.font_addr];

  vgachargen_pixel_pipe #(
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .pix_en_i (pix_en),
    .mem      (mem_if),
    .vga_r_o  (r),
    .vga_g_o  (g),
    .vga_b_o  (b),
    .vga_hs_o (hs),
    .vga_vs_o (vs)
  );

  // Output after strobe sn shows raster position sn-3; {rgb, hs, vs}.
  function automatic logic [13:0] model_out(input int sn);
    int p, h, v;
    logic [15:0] w;
    logic [7:0]  gl;
    logic        bitv;
    logic [11:0] rgb;
    if (sn < 3) return {12'h000, 2'b11};
    p   = sn - 3;
    h   = p % HT;
    v   = (p / HT) % VT;
    rgb = 12'h000;
    if (h < HA && v < VA) begin
      w    = cmap[(v / 16) * 80 + h / 8];
      gl   = font[{w[7:0], 4'(v % 16)}];
      bitv = gl[7 - (h % 8)];
      rgb  = bitv ? pal[w[11:8]] : pal[w[15:12]];
    end
    return {rgb, !(h >= HS_START && h < HS_END), !(v >= VA + VFP && v < VA + VFP + VSY)};
  endfunction

  task automatic check_out(input string name);
    logic [13:0] m, a;
    m = model_out(s);
    a = {r, g, b, hs, vs};
    checks++;
    if (a !== m) begin
      errors++;
      $display("FAIL %s strobe=%0d rgb/hs/vs got %h/%b/%b want %h/%b/%b",
               name, s, a[13:2], a[1], a[0], m[13:2], m[1], m[0]);
    end
  endtask

  task automatic check_addr();
    int h, v, p1, h1, v1, exp_a;
    logic [15:0] w;
    logic [11:0] exp_f;
    h = s % HT;
    v = (s / HT) % VT;
    if (h < HA && v < VA) begin
      exp_a = (v / 16) * 80 + h / 8;
      checks++;
      if (int'(mem_if.charmap_addr) != exp_a) begin
        errors++;
        $display("FAIL charmap_addr h=%0d v=%0d got %0d want %0d", h, v, mem_if.charmap_addr, exp_a);
      end
    end
    if (s == 16 * HT + 8) begin
      checks++;
      if (mem_if.charmap_addr !== 12'd81) begin
        errors++;
        $display("FAIL addr_cell81 got %0d want 81", mem_if.charmap_addr);
      end
    end
    if (s >= 1) begin
      p1 = s - 1;
      h1 = p1 % HT;
      v1 = (p1 / HT) % VT;
      if (h1 < HA && v1 < VA) begin
        w     = cmap[(v1 / 16) * 80 + h1 / 8];
        exp_f = {w[7:0], 4'(v1 % 16)};
        checks++;
        if (mem_if.font_addr !== exp_f) begin
          errors++;
          $display("FAIL font_addr h=%0d v=%0d got %h want %h", h1, v1, mem_if.font_addr, exp_f);
        end
      end
    end
  endtask

  task automatic strobe(input int gap);
    @(negedge clk);
    pix_en = 1'b1;
    check_addr();
    @(posedge clk);
    #1;
    s++;
    check_out("pixel");
    if (s < HT + 3 && hs == 1'b0) begin
      if (hs_cnt == 0) hs_first = s;
      hs_cnt++;
    end
    if (s < FRAME + 3 && vs == 1'b0) begin
      if (vs_cnt == 0) vs_first = s;
      vs_cnt++;
    end
    for (int k = 0; k < gap; k++) begin
      @(negedge clk);
      pix_en = 1'b0;
      @(posedge clk);
      #1;
      check_out("hold");
    end
  endtask

  task automatic do_reset(input int cycles, input logic en);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      rst    = 1'b1;
      pix_en = en;
      @(posedge clk);
      #1;
      checks++;
      if ({r, g, b, hs, vs} !== {12'h000, 2'b11}) begin
        errors++;
        $display("FAIL reset_state rgb/hs/vs got %h/%b/%b want 000/1/1", {r, g, b}, hs, vs);
      end
    end
    @(negedge clk);
    rst    = 1'b0;
    pix_en = 1'b0;
    s      = 0;
  endtask

  task automatic run_table(input int gap, input int first, input int last);
    int target;
    for (int i = first; i <= last; i++) begin
      target = vecs[i].v * HT + vecs[i].h + 3;
      while (s < target) strobe(gap);
      checks++;
      if ({r, g, b} !== vecs[i].rgb) begin
        errors++;
        $display("FAIL table[%0d] h=%0d v=%0d rgb got %h want %h",
                 i, vecs[i].h, vecs[i].v, {r, g, b}, vecs[i].rgb);
      end
    end
  endtask

  initial begin
    pal = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
            12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

    // Line 0 cell 0: code 0x41, fg F, bg 0, glyph row 0x18.
    vecs[0]  = '{0, 0, 12'h000};  vecs[1]  = '{1, 0, 12'h000};
    vecs[2]  = '{2, 0, 12'h000};  vecs[3]  = '{3, 0, 12'hFFF};
    vecs[4]  = '{4, 0, 12'hFFF};  vecs[5]  = '{5, 0, 12'h000};
    vecs[6]  = '{6, 0, 12'h000};  vecs[7]  = '{7, 0, 12'h000};
    // Line 16 cell 81: code 0x42, fg A (5F5), bg 2 (0A0), glyph row 0xA5.
    vecs[8]  = '{8,  16, 12'h5F5}; vecs[9]  = '{9,  16, 12'h0A0};
    vecs[10] = '{10, 16, 12'h5F5}; vecs[11] = '{11, 16, 12'h0A0};
    vecs[12] = '{12, 16, 12'h0A0}; vecs[13] = '{13, 16, 12'h5F5};
    vecs[14] = '{14, 16, 12'h0A0}; vecs[15] = '{15, 16, 12'h5F5};

    for (int i = 0; i < 2400; i++) cmap[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
    cmap[0]     = 16'h0F41;
    font[12'h410] = 8'h18;
    font[12'h420] = 8'hA5;

    do_reset(2, 1'b0);

    // Continuous strobes over a full frame, with a mid-frame char-map write.
    hs_first = -1; hs_cnt = 0; vs_first = -1; vs_cnt = 0;
    run_table(0, 0, 7);
    while (s < 5 * HT) strobe(0);
    cmap[81] = 16'h2A42;
    run_table(0, 8, 15);
    while (s < FRAME + HT + 10) strobe(0);

    checks++;
    if (hs_first != HS_START + 3 || hs_cnt != HS_END - HS_START) begin
      errors++;
      $display("FAIL hsync_window first=%0d count=%0d want first=%0d count=%0d",
               hs_first, hs_cnt, HS_START + 3, HS_END - HS_START);
    end
    checks++;
    if (vs_first != (VA + VFP) * HT + 3 || vs_cnt != VSY * HT) begin
      errors++;
      $display("FAIL vsync_window first=%0d count=%0d want first=%0d count=%0d",
               vs_first, vs_cnt, (VA + VFP) * HT + 3, VSY * HT);
    end

    // Reset landing at raster (300, 10) in the second frame.
    while ((s % FRAME) != 10 * HT + 300) strobe(0);
    do_reset(1, 1'b1);
    for (int i = 0; i < 2 * HT + 50; i++) strobe(0);

    // One strobe in four: same per-strobe sequence, outputs hold in between.
    do_reset(2, 1'b0);
    run_table(3, 0, 7);
    while (s < 2 * HT) strobe(3);

    // Irregular strobe spacing.
    do_reset(1, 1'b0);
    for (int i = 0; i < 1200; i++) strobe($urandom_range(0, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
